run_ctrl: RTL and testbench



---
 rtl/run_ctrl.sv | 186 ++++++++++++++++++
 tb/tb_run_ctrl.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/run_ctrl.sv
// run_ctrl -- sequences one program execution on the CPU core.
//
// On an accepted start the core is held in reset for RST_CYC cycles. It then
// receives a single-cycle req and runs until it raises done. The number of
// RUN cycles is counted and saturates at 2^CW-1. Completion is reported
// through the sticky finished flag.
//
// Optional watchdog: define RUN_CTRL_TIMEOUT_EN to abort a run once TIMEOUT
// RUN cycles have elapsed without done; the abort sets the sticky timed_out
// flag. Without the macro timed_out is tied low, RUN waits indefinitely and
// TIMEOUT is only range-checked.
//
// Parameters:
//   CW          width of cycle_count
//   RST_CYC     cycles the core is held in reset after a start (>= 1)
//   TIMEOUT     RUN-cycle limit of the watchdog (1 .. 2^CW-1)
//
// Ports:
//   clk          single clock
//   reset        synchronous active-high reset
//   start        host launch request, level sampled on every edge
//   core_done    done output of the CPU
//   core_reset   drives the CPU reset
//   core_req     drives the CPU req
//   busy         a run is in progress
//   finished     last run ended with core_done (sticky)
//   timed_out    last run was aborted by the watchdog (sticky)
//   cycle_count  RUN cycles of the current or last run

module run_ctrl #(
   parameter int CW      = 16,
   parameter int RST_CYC = 2,
   parameter int TIMEOUT = 60000
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          start,
   input  logic          core_done,
   output logic          core_reset,
   output logic          core_req,
   output logic          busy,
   output logic          finished,
   output logic          timed_out,
   output logic [CW-1:0] cycle_count
);

   // Elaboration-time parameter range checks
   if (RST_CYC < 1) begin : g_bad_rst_cyc
      $error("run_ctrl: RST_CYC must be at least 1");
   end
   if ((TIMEOUT < 1) || (longint'(TIMEOUT) > ((longint'(1) << CW) - 1))) begin : g_bad_timeout
      $error("run_ctrl: TIMEOUT must lie in 1 .. 2^CW-1");
   end

   localparam int HW = $clog2(RST_CYC + 1);
   localparam logic [HW-1:0] HOLD_LAST = HW'(RST_CYC - 1);

`ifdef RUN_CTRL_TIMEOUT_EN
   localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT - 1);

   typedef enum logic [2:0] {
      IDLE, HOLD, REQ, RUN, DONE, TOUT
   } state_t;
`else
   typedef enum logic [2:0] {
      IDLE, HOLD, REQ, RUN, DONE
   } state_t;
`endif

   state_t        state;
   state_t        state_next;
   logic [HW-1:0] hold_cnt;
   logic          launch;
   logic          run_edge;
   logic          set_finished;
`ifdef RUN_CTRL_TIMEOUT_EN
   logic          set_timed_out;
   logic          timed_out_q;
`endif

   // Next-state decode. launch marks the edge that accepts a start, run_edge
   // marks every edge taken from RUN (including the one that leaves it).
   always_comb begin
      state_next    = state;
      launch        = 1'b0;
      run_edge      = 1'b0;
      set_finished  = 1'b0;
`ifdef RUN_CTRL_TIMEOUT_EN
      set_timed_out = 1'b0;
`endif
      case (state)
         IDLE, DONE: begin
            if (start) begin
               state_next = HOLD;
               launch     = 1'b1;
            end
         end
`ifdef RUN_CTRL_TIMEOUT_EN
         TOUT: begin
            if (start) begin
               state_next = HOLD;
               launch     = 1'b1;
            end
         end
`endif
         HOLD: begin
            if (hold_cnt == HOLD_LAST) begin
               state_next = REQ;
            end
         end
         REQ: begin
            state_next = RUN;
         end
         RUN: begin
            run_edge = 1'b1;
            // done has priority over a watchdog expiry on the same edge
            if (core_done) begin
               state_next   = DONE;
               set_finished = 1'b1;
            end
`ifdef RUN_CTRL_TIMEOUT_EN
            else if (cycle_count == TMO_LAST) begin
               state_next    = TOUT;
               set_timed_out = 1'b1;
            end
`endif
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // State register, hold counter, saturating cycle counter, sticky flags
   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= IDLE;
         hold_cnt    <= '0;
         cycle_count <= '0;
         finished    <= 1'b0;
`ifdef RUN_CTRL_TIMEOUT_EN
         timed_out_q <= 1'b0;
`endif
      end else begin
         state <= state_next;

         if (launch) begin
            hold_cnt <= '0;
         end else if (state == HOLD) begin
            hold_cnt <= hold_cnt + 1'b1;
         end

         if (launch) begin
            cycle_count <= '0;
         end else if (run_edge && (cycle_count != '1)) begin
            cycle_count <= cycle_count + 1'b1;
         end

         if (launch) begin
            finished <= 1'b0;
         end else if (set_finished) begin
            finished <= 1'b1;
         end

`ifdef RUN_CTRL_TIMEOUT_EN
         if (launch) begin
            timed_out_q <= 1'b0;
         end else if (set_timed_out) begin
            timed_out_q <= 1'b1;
         end
`endif
      end
   end

`ifdef RUN_CTRL_TIMEOUT_EN
   assign timed_out = timed_out_q;
`else
   assign timed_out = 1'b0;
`endif

   // Core controls and busy are decoded purely from the state register
   assign core_reset = (state != REQ) && (state != RUN);
   assign core_req   = (state == REQ);
   assign busy       = (state == HOLD) || (state == REQ) || (state == RUN);

endmodule

// File: tb/tb_run_ctrl.sv
// tb_run_ctrl -- directed self-checking bench for run_ctrl.
// Configuration: CW=8, RST_CYC=2, TIMEOUT=20. Inputs change 1 time unit after
// a rising edge and outputs are sampled at the same point, so every check
// sees the result of the preceding edge.

module tb_run_ctrl;

   localparam int CW      = 8;
   localparam int RST_CYC = 2;
   localparam int TIMEOUT = 20;

   logic          clk = 1'b0;
   logic          reset;
   logic          start;
   logic          core_done;
   logic          core_reset;
   logic          core_req;
   logic          busy;
   logic          finished;
   logic          timed_out;
   logic [CW-1:0] cycle_count;

   int tests_run    = 0;
   int tests_failed = 0;

   always #5 clk = ~clk;

   run_ctrl #(
      .CW      (CW),
      .RST_CYC (RST_CYC),
      .TIMEOUT (TIMEOUT)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .start       (start),
      .core_done   (core_done),
      .core_reset  (core_reset),
      .core_req    (core_req),
      .busy        (busy),
      .finished    (finished),
      .timed_out   (timed_out),
      .cycle_count (cycle_count)
   );

   // Advance to just after the next rising edge
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input logic startVal, input logic doneVal);
      start     = startVal;
      core_done = doneVal;
   endtask

   task automatic checkVal(input string tag, input logic [31:0] observed,
                           input logic [31:0] expected);
      tests_run++;
      assert (observed === expected)
      else begin
         tests_failed++;
         $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
      end
   endtask

   task automatic checkOutput(input string tag, input logic expRst, input logic expReq,
                              input logic expBusy, input logic expFin,
                              input logic expTout, input int expCnt);
      checkVal({tag, ".core_reset"},  {31'd0, core_reset}, {31'd0, expRst});
      checkVal({tag, ".core_req"},    {31'd0, core_req},   {31'd0, expReq});
      checkVal({tag, ".busy"},        {31'd0, busy},       {31'd0, expBusy});
      checkVal({tag, ".finished"},    {31'd0, finished},   {31'd0, expFin});
      checkVal({tag, ".timed_out"},   {31'd0, timed_out},  {31'd0, expTout});
      checkVal({tag, ".cycle_count"}, {24'd0, cycle_count}, expCnt);
   endtask

   // One start pulse, then walk HOLD, HOLD, REQ and into the first RUN cycle.
   // Flags must already be clear right after the accepting edge.
   task automatic launchRun(input string tag, input logic doneInHold);
      applyStimulus(1'b1, 1'b0);
      tick();
      applyStimulus(1'b0, doneInHold);
      checkOutput({tag, "_hold1"}, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 0);
      tick();
      checkOutput({tag, "_hold2"}, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 0);
      tick();
      checkOutput({tag, "_req"},   1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 0);
      tick();
      applyStimulus(1'b0, 1'b0);
      checkOutput({tag, "_run0"},  1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 0);
   endtask

   initial begin
      reset = 1'b1;
      applyStimulus(1'b0, 1'b0);

      // Reset and idle
      tick();
      checkOutput("reset", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0);
      tick();
      reset = 1'b0;
      for (int i = 0; i < 5; i++) tick();
      checkOutput("idle", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0);

      // Run 1: done sampled on RUN edge 7
      launchRun("run1", 1'b0);
      for (int i = 1; i <= 6; i++) begin
         tick();
         checkOutput("run1_run", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, i);
      end
      applyStimulus(1'b0, 1'b1);
      tick();
      applyStimulus(1'b0, 1'b0);
      checkOutput("run1_done", 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 7);

      // Run 2 launched from the single DONE cycle; done pulsed in HOLD/REQ
      // and start re-pulsed in RUN must both be ignored
      launchRun("run2", 1'b1);
      tick();
      tick();
      checkOutput("run2_run2", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2);
      applyStimulus(1'b1, 1'b0);
      tick();
      applyStimulus(1'b0, 1'b0);
      checkOutput("run2_restart", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3);
      tick();
      checkOutput("run2_run4", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4);
      applyStimulus(1'b0, 1'b1);
      tick();
      applyStimulus(1'b0, 1'b0);
      checkOutput("run2_done", 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 5);
      tick();
      checkOutput("run2_sticky", 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 5);

      // Run 3: done arrives on the edge where the watchdog would expire
      launchRun("run3", 1'b0);
      for (int i = 1; i <= 19; i++) tick();
      checkOutput("run3_run19", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 19);
      applyStimulus(1'b0, 1'b1);
      tick();
      applyStimulus(1'b0, 1'b0);
      checkOutput("run3_done", 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 20);

      // Run 4: core never finishes
      launchRun("run4", 1'b0);
`ifdef RUN_CTRL_TIMEOUT_EN
      for (int i = 1; i <= 19; i++) tick();
      checkOutput("run4_run19", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 19);
      tick();
      checkOutput("run4_tout", 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 20);
      tick();
      checkOutput("run4_sticky", 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 20);
`else
      for (int i = 1; i <= 300; i++) tick();
      checkOutput("run4_sat", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 255);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      checkOutput("run4_reset", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0);
`endif

      // Run 5: reset in RUN cycle 4 with start asserted, then a fresh run
      launchRun("run5", 1'b0);
      for (int i = 1; i <= 3; i++) tick();
      checkOutput("run5_run3", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3);
      applyStimulus(1'b1, 1'b0);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      applyStimulus(1'b0, 1'b0);
      checkOutput("run5_reset", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0);
      tick();
      checkOutput("run5_idle", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0);
      launchRun("run6", 1'b0);
      tick();
      tick();
      applyStimulus(1'b0, 1'b1);
      tick();
      applyStimulus(1'b0, 1'b0);
      checkOutput("run6_done", 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 3);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
